// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state type, op decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int unsigned wide = 32
) (
  input  logic [wide-1:0] din,
  input  logic            neg,
  output logic [wide-1:0] dout
);

  assign dout = neg ? ((~din) + wide'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative HI/LO multiply/divide unit with MTHI/MTLO writes.
// Optional MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle product.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned wide = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [wide-1:0] a,
  input  logic [wide-1:0] b,
  input  logic            we_hi,
  input  logic            we_lo,
  input  logic [wide-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [wide-1:0] hi,
  output logic [wide-1:0] lo
);

  localparam int unsigned CntW = (wide > 1) ? $clog2(wide) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(wide - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      op_q;
  logic            sign_q;     // product / quotient negate
  logic            rem_neg_q;  // remainder takes dividend sign
  logic            dz_q;
  logic [wide:0]   p_hi_q;     // accumulator or partial remainder
  logic [wide-1:0] p_lo_q;     // multiplier or dividend/quotient
  logic [wide-1:0] mcand_q;    // multiplicand or divisor magnitude

  logic [wide-1:0] a_abs, b_abs;
  logic            start_sign;

  assign start_sign = op_is_signed(op) & (a[wide-1] ^ b[wide-1]);

  muldiv_negate #(.wide(wide)) u_abs_a (
    .din  (a),
    .neg  (op_is_signed(op) & a[wide-1]),
    .dout (a_abs)
  );

  muldiv_negate #(.wide(wide)) u_abs_b (
    .din  (b),
    .neg  (op_is_signed(op) & b[wide-1]),
    .dout (b_abs)
  );

  // One iteration of shift-add multiply or restoring divide.
  logic [wide:0]   mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [wide:0]   step_hi;
  logic [wide-1:0] step_lo;

  always_comb begin
    mul_sum   = p_hi_q + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {p_hi_q[wide-1:0], p_lo_q[wide-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_diff  = div_shift - {1'b0, mcand_q};
    if (op_is_div(op_q)) begin
      step_hi = div_ge ? div_diff : div_shift;
      step_lo = {p_lo_q[wide-2:0], div_ge};
    end else begin
      step_hi = {1'b0, mul_sum[wide:1]};
      step_lo = {mul_sum[0], p_lo_q[wide-1:1]};
    end
  end

  logic [2*wide-1:0] prod_fix;
  logic [wide-1:0]   quo_fix, rem_fix;

  muldiv_negate #(.wide(2 * wide)) u_fix_prod (
    .din  ({step_hi[wide-1:0], step_lo}),
    .neg  (sign_q),
    .dout (prod_fix)
  );

  muldiv_negate #(.wide(wide)) u_fix_quo (
    .din  (step_lo),
    .neg  (sign_q),
    .dout (quo_fix)
  );

  muldiv_negate #(.wide(wide)) u_fix_rem (
    .din  (step_hi[wide-1:0]),
    .neg  (rem_neg_q),
    .dout (rem_fix)
  );

  logic [wide-1:0] res_hi, res_lo;

  // Zero divisor leaves |a| as remainder, which the dividend-sign fix-up turns back into a.
  always_comb begin
    if (op_is_div(op_q)) begin
      res_hi = rem_fix;
      res_lo = dz_q ? '1 : quo_fix;
    end else begin
      {res_hi, res_lo} = prod_fix;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*wide-1:0] fast_mag, fast_res;

  assign fast_mag = (2 * wide)'(a_abs) * (2 * wide)'(b_abs);

  muldiv_negate #(.wide(2 * wide)) u_fix_fast (
    .din  (fast_mag),
    .neg  (start_sign),
    .dout (fast_res)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OP_MULTU;
      sign_q    <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      mcand_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_q  <= StIdle;
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            op_q      <= op;
            sign_q    <= start_sign;
            rem_neg_q <= op_is_signed(op) & a[wide-1];
            dz_q      <= op_is_div(op) & (b == '0);
            cnt_q     <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= a_abs;
            mcand_q   <= b_abs;
`ifdef MULDIV_FAST_MUL_EN
            if (!op_is_div(op)) begin
              {hi, lo} <= fast_res;
              state_q  <= StDone;
              done     <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
            end
`else
            state_q <= StRun;
            busy    <= 1'b1;
`endif
          end else begin
            if (we_hi) hi <= wd;
            if (we_lo) lo <= wd;
          end
        end
        StRun: begin
          p_hi_q <= step_hi;
          p_lo_q <= step_lo;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= dz_q;
            hi       <= res_hi;
            lo       <= res_lo;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
